// File: rtl/sample_framer.sv
// Frame collector in front of the 16-point FFT: gathers samples into frames,
// holds each launched frame stable, and sequences the FFT start/done handshake.
module sample_framer #(
  parameter int N_SAMPLES = 16,
  parameter int SAMPLE_W  = 16,
  parameter int WORD_W    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SAMPLE_W-1:0]             sample_in,
  input  logic                            sample_valid,
  input  logic                            fft_done,
  output logic [N_SAMPLES*WORD_W-1:0]     frame_out,
  output logic                            frame_start,
  output logic                            busy,
  output logic [$clog2(N_SAMPLES):0]      fill_level,
  output logic [7:0]                      overrun_count
);

  localparam int IDX_W = $clog2(N_SAMPLES);
  localparam int PAD_W = WORD_W - SAMPLE_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    WAIT_HIGH = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;

  logic [SAMPLE_W-1:0] capture_r [N_SAMPLES];
  logic [SAMPLE_W-1:0] pending_r [N_SAMPLES];
  logic [SAMPLE_W-1:0] output_r  [N_SAMPLES];

  logic [IDX_W-1:0]    wr_idx_r;
  logic                pending_valid_r;
  logic                frame_start_r;
  logic                busy_r;
  logic [7:0]          overrun_count_r;

  logic                frame_done_s;
  logic                launch_s;
  logic                release_s;

  assign frame_done_s = sample_valid && (wr_idx_r == IDX_W'(N_SAMPLES - 1));

  // Capture buffer and write index; the index wraps naturally at N_SAMPLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_r <= '0;
      for (int k = 0; k < N_SAMPLES; k++) begin
        capture_r[k] <= '0;
      end
    end else if (sample_valid) begin
      capture_r[wr_idx_r] <= sample_in;
      wr_idx_r            <= wr_idx_r + IDX_W'(1);
    end else begin
      wr_idx_r <= wr_idx_r;
    end
  end

  // Pending frame slot: newest completed frame wins, a displaced unlaunched frame counts as an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_valid_r <= 1'b0;
      overrun_count_r <= 8'd0;
      for (int k = 0; k < N_SAMPLES; k++) begin
        pending_r[k] <= '0;
      end
    end else if (frame_done_s) begin
      for (int k = 0; k < N_SAMPLES - 1; k++) begin
        pending_r[k] <= capture_r[k];
      end
      pending_r[N_SAMPLES-1] <= sample_in;
      pending_valid_r        <= 1'b1;
      if (pending_valid_r && !launch_s && (overrun_count_r != 8'hFF)) begin
        overrun_count_r <= overrun_count_r + 8'd1;
      end else begin
        overrun_count_r <= overrun_count_r;
      end
    end else if (launch_s) begin
      pending_valid_r <= 1'b0;
    end else begin
      pending_valid_r <= pending_valid_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; WAIT_LOW skips a done level left over from the previous run.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (pending_valid_r) begin
          state_next_s = WAIT_LOW;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT_LOW: begin
        if (!fft_done) begin
          state_next_s = WAIT_HIGH;
        end else begin
          state_next_s = WAIT_LOW;
        end
      end
      WAIT_HIGH: begin
        if (fft_done) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_HIGH;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM decoded actions.
  always_comb begin
    launch_s  = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE:      launch_s  = pending_valid_r;
      WAIT_LOW:  release_s = 1'b0;
      WAIT_HIGH: release_s = fft_done;
      default: begin
        launch_s  = 1'b0;
        release_s = 1'b0;
      end
    endcase
  end

  // Launch side: output array, start pulse and busy flag all move on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start_r <= 1'b0;
      busy_r        <= 1'b0;
      for (int k = 0; k < N_SAMPLES; k++) begin
        output_r[k] <= '0;
      end
    end else begin
      frame_start_r <= launch_s;
      if (launch_s) begin
        busy_r <= 1'b1;
        for (int k = 0; k < N_SAMPLES; k++) begin
          output_r[k] <= pending_r[k];
        end
      end else if (release_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  // Each FFT word carries the sample in its MSBs, zero-filled below.
  for (genvar g = 0; g < N_SAMPLES; g++) begin : g_pack
    if (PAD_W > 0) begin : g_pad
      assign frame_out[g*WORD_W +: WORD_W] = {output_r[g], {PAD_W{1'b0}}};
    end else begin : g_nopad
      assign frame_out[g*WORD_W +: WORD_W] = output_r[g];
    end
  end

  assign frame_start   = frame_start_r;
  assign busy          = busy_r;
  assign fill_level    = {1'b0, wr_idx_r};
  assign overrun_count = overrun_count_r;

endmodule
